// File: rtl/obuf_a_data.sv
// Output buffer toward a neighbour router. It is a DEPTH-entry FIFO with registered ready/valid.
// Optional stall counter output stall_cnt is enabled by defining OBUF_A_STALL_CNT_EN.
module obuf_a_data #(
  parameter int unsigned PYLD_W = 17,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pg_en,
  input  logic              xbar_vld,
  input  logic [PYLD_W-1:0] payload_i,
  output logic              obuf_rdy,
  output logic              tx_vld,
  output logic [PYLD_W-1:0] tx_payload,
  input  logic              tx_rdy
`ifdef OBUF_A_STALL_CNT_EN
  ,
  output logic [7:0]        stall_cnt
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [PYLD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;

  // Handshakes depend only on registered state and pg_en, so there is no tx_rdy->obuf_rdy path.
  always_comb begin
    obuf_rdy   = (count != FULL_CNT) & ~pg_en;
    tx_vld     = (count != '0) & ~pg_en;
    tx_payload = mem[rd_ptr];
    push       = xbar_vld & obuf_rdy;
    pop        = tx_vld & tx_rdy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= payload_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef OBUF_A_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (pg_en) begin
      stall_cnt <= stall_cnt;
    end else if (pop) begin
      stall_cnt <= '0;
    end else if (tx_vld && !tx_rdy && stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_obuf_a_data.sv
// Directed bench for obuf_a_data. It covers single transfer, backpressure, full with pop, pg_en hold, and reset.
// It also covers the stall counter when OBUF_A_STALL_CNT_EN is defined.
module tb_obuf_a_data;

  localparam int unsigned PYLD_W = 17;

  logic              clk;
  logic              rst_n;
  logic              pg_en;
  logic              xbar_vld;
  logic [PYLD_W-1:0] payload_i;
  logic              obuf_rdy;
  logic              tx_vld;
  logic [PYLD_W-1:0] tx_payload;
  logic              tx_rdy;
`ifdef OBUF_A_STALL_CNT_EN
  logic [7:0]        stall_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  obuf_a_data #(.PYLD_W(PYLD_W), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pg_en      (pg_en),
    .xbar_vld   (xbar_vld),
    .payload_i  (payload_i),
    .obuf_rdy   (obuf_rdy),
    .tx_vld     (tx_vld),
    .tx_payload (tx_payload),
    .tx_rdy     (tx_rdy)
`ifdef OBUF_A_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    pg_en     = 1'b0;
    xbar_vld  = 1'b0;
    payload_i = '0;
    tx_rdy    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_obuf_rdy", 32'(obuf_rdy), 32'd1);
    check("rst_tx_vld", 32'(tx_vld), 32'd0);
    check("rst_tx_payload", 32'(tx_payload), 32'h0);
`ifdef OBUF_A_STALL_CNT_EN
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Single transfer
    tx_rdy = 1'b1; xbar_vld = 1'b1; payload_i = 17'h1A5A5;
    #1;
    check("single_no_bypass", 32'(tx_vld), 32'd0);
    step();
    xbar_vld = 1'b0;
    check("single_tx_vld", 32'(tx_vld), 32'd1);
    check("single_payload", 32'(tx_payload), 32'h1A5A5);
    step();
    check("single_drained", 32'(tx_vld), 32'd0);
    check("single_rdy", 32'(obuf_rdy), 32'd1);

    // Fill and backpressure; C is offered while full and must be dropped
    tx_rdy = 1'b0; xbar_vld = 1'b1; payload_i = 17'h0000A;
    step();
    check("fill_a_vld", 32'(tx_vld), 32'd1);
    check("fill_a_rdy", 32'(obuf_rdy), 32'd1);
    payload_i = 17'h0000B;
    step();
    check("fill_full_rdy", 32'(obuf_rdy), 32'd0);
    check("fill_head_a", 32'(tx_payload), 32'h0000A);
    payload_i = 17'h0000C;
    step();
    check("fill_hold_vld", 32'(tx_vld), 32'd1);
    check("fill_hold_a", 32'(tx_payload), 32'h0000A);
    xbar_vld = 1'b0; tx_rdy = 1'b1;
    step();
    check("fill_head_b", 32'(tx_payload), 32'h0000B);
    check("fill_b_vld", 32'(tx_vld), 32'd1);
    step();
    check("fill_no_c", 32'(tx_vld), 32'd0);
    step();
    check("fill_no_c2", 32'(tx_vld), 32'd0);

    // Full with simultaneous pop: F must not be stored
    tx_rdy = 1'b0; xbar_vld = 1'b1; payload_i = 17'h0000D;
    step();
    payload_i = 17'h0000E;
    step();
    check("fullpop_full", 32'(obuf_rdy), 32'd0);
    payload_i = 17'h0000F; tx_rdy = 1'b1;
    step();
    xbar_vld = 1'b0;
    check("fullpop_rdy_next", 32'(obuf_rdy), 32'd1);
    check("fullpop_head_e", 32'(tx_payload), 32'h0000E);
    step();
    check("fullpop_no_f", 32'(tx_vld), 32'd0);

    // pg_en holds the port; pushes offered during the hold are refused
    tx_rdy = 1'b0; xbar_vld = 1'b1; payload_i = 17'h12345;
    step();
    xbar_vld = 1'b0;
    check("pg_stored", 32'(tx_vld), 32'd1);
    pg_en = 1'b1; tx_rdy = 1'b1; xbar_vld = 1'b1; payload_i = 17'h00077;
    #1;
    check("pg_tx_vld_now", 32'(tx_vld), 32'd0);
    check("pg_rdy_now", 32'(obuf_rdy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("pg_tx_vld", 32'(tx_vld), 32'd0);
      check("pg_obuf_rdy", 32'(obuf_rdy), 32'd0);
    end
    xbar_vld = 1'b0; pg_en = 1'b0;
    #1;
    check("pg_resume_vld", 32'(tx_vld), 32'd1);
    check("pg_resume_data", 32'(tx_payload), 32'h12345);
    step();
    check("pg_drained", 32'(tx_vld), 32'd0);

    // Reset with two entries stored
    tx_rdy = 1'b0; xbar_vld = 1'b1; payload_i = 17'h00111;
    step();
    payload_i = 17'h00222;
    step();
    xbar_vld = 1'b0;
    check("rst2_full", 32'(obuf_rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst2_tx_vld", 32'(tx_vld), 32'd0);
    check("rst2_obuf_rdy", 32'(obuf_rdy), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("rst2_empty", 32'(tx_vld), 32'd0);
    tx_rdy = 1'b1; xbar_vld = 1'b1; payload_i = 17'h00333;
    step();
    xbar_vld = 1'b0;
    check("rst2_first_vld", 32'(tx_vld), 32'd1);
    check("rst2_first_data", 32'(tx_payload), 32'h00333);
    step();
    check("rst2_no_stale", 32'(tx_vld), 32'd0);

`ifdef OBUF_A_STALL_CNT_EN
    // Stall counter: counts, saturates, freezes under pg_en, clears on pop
    tx_rdy = 1'b0; xbar_vld = 1'b1; payload_i = 17'h00444;
    step();
    xbar_vld = 1'b0;
    check("stall_start", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 10; i++) step();
    check("stall_10", 32'(stall_cnt), 32'd10);
    pg_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("stall_frozen", 32'(stall_cnt), 32'd10);
    pg_en = 1'b0;
    for (int i = 0; i < 300; i++) step();
    check("stall_sat", 32'(stall_cnt), 32'd255);
    tx_rdy = 1'b1;
    step();
    check("stall_clear", 32'(stall_cnt), 32'd0);
    check("stall_drained", 32'(tx_vld), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
